// File: rtl/chaos_round_key_gen.sv
// Chaos-based round-key generator.
// A logistic map on a Q0.32 state is seeded from the folded master key. It runs
// BURN discarded iterations, then emits ROUND keys. Each key is built from four
// consecutive map outputs and XORed with the latched master key.
//
// state  | meaning
// S_IDLE | waiting for start; map state held
// S_BURN | discarding map iterations after seeding
// S_GEN  | capturing map words and emitting one key every four cycles
module chaos_round_key_gen #(
  parameter int ROUND    = 5,
  parameter int KEY_SIZE = 128,
  parameter int BURN     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [KEY_SIZE-1:0] seed,
  output logic                tvalid,
  output logic [KEY_SIZE-1:0] key,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BURN = 2'd1,
    S_GEN  = 2'd2
  } state_t;

  localparam logic [31:0] GOLDEN     = 32'h9E3779B9;
  localparam logic [7:0]  BURN_LAST  = (BURN == 0) ? 8'd0 : 8'(BURN - 1);
  localparam logic [15:0] ROUND_LAST = 16'(ROUND - 1);

  state_t                state;
  logic [31:0]           x;
  logic [31:0]           x_next;
  logic [31:0]           x_seed;
  logic [KEY_SIZE-1:0]   seed_q;
  logic [7:0]            burn_cnt;
  logic [1:0]            word_cnt;
  logic [15:0]           key_cnt;
  logic [31:0]           w0;
  logic [31:0]           w1;
  logic [31:0]           w2;

  // x' = 4x(1-x) in Q0.32. The escape constant kicks the state off the zero and
  // fixed-point attractors so that the sequence cannot lock up.
  function automatic logic [31:0] map_step(input logic [31:0] xi);
    logic [63:0] p;
    logic [31:0] m;
    p = {32'd0, xi} * (64'h0000_0001_0000_0000 - {32'd0, xi});
    m = p[61:30];
    if ((m == 32'd0) || (m == xi)) begin
      return m ^ GOLDEN;
    end
    return m;
  endfunction

  // Next map value, and the initial state folded from the incoming seed.
  always_comb begin
    x_next = map_step(x);
    x_seed = seed[127:96] ^ seed[95:64] ^ seed[63:32] ^ seed[31:0];
    if (x_seed == 32'd0) begin
      x_seed = GOLDEN;
    end
  end

  assign busy = (state != S_IDLE);

  // Sequencer: seeding, burn-in, word capture, key emission and strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      x        <= '0;
      seed_q   <= '0;
      burn_cnt <= '0;
      word_cnt <= '0;
      key_cnt  <= '0;
      w0       <= '0;
      w1       <= '0;
      w2       <= '0;
      key      <= '0;
      tvalid   <= 1'b0;
      done     <= 1'b0;
    end else begin
      tvalid <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x        <= x_seed;
            seed_q   <= seed;
            burn_cnt <= BURN_LAST;
            word_cnt <= 2'd0;
            key_cnt  <= 16'd0;
            state    <= (BURN == 0) ? S_GEN : S_BURN;
          end
        end
        S_BURN: begin
          x <= x_next;
          if (burn_cnt == 8'd0) begin
            state <= S_GEN;
          end else begin
            burn_cnt <= burn_cnt - 8'd1;
          end
        end
        S_GEN: begin
          x        <= x_next;
          word_cnt <= word_cnt + 2'd1;
          case (word_cnt)
            2'd0: w0 <= x_next;
            2'd1: w1 <= x_next;
            2'd2: w2 <= x_next;
            default: begin
              key    <= {w0, w1, w2, x_next} ^ seed_q;
              tvalid <= 1'b1;
              if (key_cnt == ROUND_LAST) begin
                done    <= 1'b1;
                key_cnt <= 16'd0;
                state   <= S_IDLE;
              end else begin
                key_cnt <= key_cnt + 16'd1;
              end
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chaos_round_key_gen.sv
// Bench for chaos_round_key_gen: two instances (BURN=16 and BURN=0) checked
// cycle by cycle against a key-sequence model computed from the map rules.
module tb_chaos_round_key_gen;

  localparam int ROUND  = 5;
  localparam int BURN_A = 16;
  localparam int BURN_B = 0;
  localparam logic [31:0] GOLDEN = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start_a, start_b;
  logic [127:0] seed_a, seed_b;
  logic         tvalid_a, tvalid_b;
  logic [127:0] key_a, key_b;
  logic         busy_a, busy_b;
  logic         done_a, done_b;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_keys [0:ROUND-1];
  logic [127:0] got_keys [0:ROUND-1];
  logic [127:0] first_keys [0:ROUND-1];
  logic [127:0] exp_last [0:1];

  always #5 clk = ~clk;

  chaos_round_key_gen #(.ROUND(ROUND), .KEY_SIZE(128), .BURN(BURN_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .seed(seed_a),
    .tvalid(tvalid_a), .key(key_a), .busy(busy_a), .done(done_a)
  );

  chaos_round_key_gen #(.ROUND(ROUND), .KEY_SIZE(128), .BURN(BURN_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .seed(seed_b),
    .tvalid(tvalid_b), .key(key_b), .busy(busy_b), .done(done_b)
  );

  // Logistic map x' = 4x(1-x) with the escape rule, in plain 64-bit arithmetic.
  function automatic logic [31:0] model_map(input logic [31:0] xv);
    longint unsigned xl, p;
    logic [31:0] m;
    xl = longint'(xv);
    p  = xl * (64'd4294967296 - xl);
    m  = 32'((p >> 30) & 64'hFFFF_FFFF);
    if (m == 32'd0 || m == xv) return m ^ GOLDEN;
    return m;
  endfunction

  function automatic void compute_keys(input logic [127:0] s, input int burn);
    logic [31:0] xv;
    logic [31:0] w [0:3];
    xv = s[127:96] ^ s[95:64] ^ s[63:32] ^ s[31:0];
    if (xv == 32'd0) xv = GOLDEN;
    for (int i = 0; i < burn; i++) xv = model_map(xv);
    for (int j = 0; j < ROUND; j++) begin
      for (int i = 0; i < 4; i++) begin
        xv = model_map(xv);
        w[i] = xv;
      end
      exp_keys[j] = {w[0], w[1], w[2], w[3]} ^ s;
    end
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_start(input bit sel, input logic v, input logic [127:0] s);
    if (sel) begin
      start_b = v;
      seed_b  = s;
    end else begin
      start_a = v;
      seed_a  = s;
    end
  endtask

  // One run on the selected instance, checked every cycle from E0 to the last key.
  // Entered and left 1 time unit after a rising edge.
  task automatic run_one(input bit sel, input logic [127:0] s, input bit hold,
                         input int inj_k, input int abort_n, input string name);
    int burn, last, j, nv;
    logic tv, dn, bz, exp_tv, exp_dn;
    logic [127:0] ky;
    burn = sel ? BURN_B : BURN_A;
    last = burn + 4 * ROUND;
    compute_keys(s, burn);
    drive_start(sel, 1'b1, s);
    @(posedge clk); #1;
    drive_start(sel, hold, hold ? s : ~s);
    bz = sel ? busy_b : busy_a;
    tv = sel ? tvalid_b : tvalid_a;
    total++;
    if (bz !== 1'b1 || tv !== 1'b0) begin
      bad++;
      $display("FAIL %s accept: busy=%b tvalid=%b want busy=1 tvalid=0", name, bz, tv);
    end
    nv = 0;
    for (int k = 1; k <= last; k++) begin
      if (k == inj_k) drive_start(sel, 1'b1, s ^ 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978);
      @(posedge clk); #1;
      if (k == inj_k) drive_start(sel, hold, hold ? s : ~s);
      tv = sel ? tvalid_b : tvalid_a;
      dn = sel ? done_b : done_a;
      bz = sel ? busy_b : busy_a;
      ky = sel ? key_b : key_a;
      exp_tv = (k > burn) && (((k - burn) % 4) == 0);
      j = (k - burn) / 4 - 1;
      exp_dn = exp_tv && (j == ROUND - 1);
      if (exp_tv) exp_last[sel] = exp_keys[j];
      total++;
      if (tv !== exp_tv) begin
        bad++;
        $display("FAIL %s tvalid k=%0d: got=%b want=%b", name, k, tv, exp_tv);
      end
      total++;
      if (dn !== exp_dn) begin
        bad++;
        $display("FAIL %s done k=%0d: got=%b want=%b", name, k, dn, exp_dn);
      end
      total++;
      if (bz !== (k < last)) begin
        bad++;
        $display("FAIL %s busy k=%0d: got=%b want=%b", name, k, bz, (k < last));
      end
      total++;
      if (ky !== exp_last[sel]) begin
        bad++;
        $display("FAIL %s key k=%0d: got=%h want=%h", name, k, ky, exp_last[sel]);
      end
      if (exp_tv) begin
        got_keys[j] = ky;
        nv++;
        if (abort_n != 0 && nv == abort_n) return;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_start(1'b0, 1'b0, '0);
    drive_start(1'b1, 1'b0, '0);
    exp_last[0] = '0;
    exp_last[1] = '0;
    #12;
    total++;
    if ({tvalid_a, busy_a, done_a} !== 3'b000 || key_a !== '0) begin
      bad++;
      $display("FAIL reset_a: tvalid=%b busy=%b done=%b key=%h want all 0", tvalid_a, busy_a, done_a, key_a);
    end
    total++;
    if ({tvalid_b, busy_b, done_b} !== 3'b000 || key_b !== '0) begin
      bad++;
      $display("FAIL reset_b: tvalid=%b busy=%b done=%b key=%h want all 0", tvalid_b, busy_b, done_b, key_b);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_degenerate();
    logic [127:0] s;
    s = {32'h80000000, 96'h0};
    run_one(1'b1, s, 1'b0, 0, 0, "zero_guard");
    total++;
    if (got_keys[0][127:96] !== 32'h1E3779B9) begin
      bad++;
      $display("FAIL zero_guard word0: got=%h want=1e3779b9", got_keys[0][127:96]);
    end
    s = {32'hC0000000, 96'h0};
    run_one(1'b1, s, 1'b0, 0, 0, "fixed_guard");
    total++;
    if (got_keys[0][127:96] !== 32'h9E3779B9) begin
      bad++;
      $display("FAIL fixed_guard word0: got=%h want=9e3779b9", got_keys[0][127:96]);
    end
  endtask

  task automatic test_seed_zero();
    run_one(1'b0, 128'h0, 1'b0, 0, 0, "seed_zero");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      run_one(1'b0, rand128(), 1'b0, 0, 0, "random_a");
      run_one(1'b1, rand128(), 1'b0, 0, 0, "random_b");
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] s;
    s = rand128();
    run_one(1'b0, s, 1'b1, 0, 0, "b2b_run1");
    for (int j = 0; j < ROUND; j++) first_keys[j] = got_keys[j];
    run_one(1'b0, s, 1'b1, 0, 0, "b2b_run2");
    drive_start(1'b0, 1'b0, s);
    for (int j = 0; j < ROUND; j++) begin
      total++;
      if (got_keys[j] !== first_keys[j]) begin
        bad++;
        $display("FAIL b2b_repeat key%0d: got=%h want=%h", j, got_keys[j], first_keys[j]);
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      total++;
      if (tvalid_a !== 1'b0 || busy_a !== 1'b0) begin
        bad++;
        $display("FAIL b2b_quiet k=%0d: tvalid=%b busy=%b want 0 0", k, tvalid_a, busy_a);
      end
    end
  endtask

  task automatic test_ignore_busy_start();
    run_one(1'b0, rand128(), 1'b0, 6, 0, "ignore_early");
    run_one(1'b0, rand128(), 1'b0, 23, 0, "ignore_gen");
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] s;
    s = rand128();
    run_one(1'b0, s, 1'b0, 0, 2, "abort");
    #2;
    reset_n = 1'b0;
    exp_last[0] = '0;
    exp_last[1] = '0;
    #1;
    total++;
    if ({tvalid_a, busy_a, done_a} !== 3'b000 || key_a !== '0) begin
      bad++;
      $display("FAIL abort_async: tvalid=%b busy=%b done=%b key=%h want all 0", tvalid_a, busy_a, done_a, key_a);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      total++;
      if (tvalid_a !== 1'b0 || busy_a !== 1'b0 || key_a !== '0) begin
        bad++;
        $display("FAIL abort_quiet k=%0d: tvalid=%b busy=%b key=%h want 0 0 0", k, tvalid_a, busy_a, key_a);
      end
    end
    run_one(1'b0, s, 1'b0, 0, 0, "after_abort");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_degenerate();
    test_seed_zero();
    test_random();
    test_back_to_back();
    test_ignore_busy_start();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
